// File: rtl/coco_load_align.sv
// Load aligner: fetches DW-wide memory beats and returns a zero/sign-extended byte, half, word or full field.
// Define COCO_LOAD_SPLIT_EN to run misaligned loads as two aligned reads; otherwise they return an error.
module coco_load_align #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic [2:0]    req_funct,
    output logic          mem_rd_valid,
    output logic [31:0]   mem_rd_addr,
    input  logic          mem_rd_ready,
    input  logic          mem_rdata_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

`ifdef COCO_LOAD_SPLIT_EN
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, RESP} state_t;
`endif

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      funct_q, funct_d;
    logic            req_ready_q, req_ready_d;
    logic            mem_rd_valid_q, mem_rd_valid_d;
    logic [31:0]     mem_rd_addr_q, mem_rd_addr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
`ifdef COCO_LOAD_SPLIT_EN
    logic            split_q, split_d;
    logic [DW-1:0]   beat0_q, beat0_d;
`endif
    logic [31:0]     base_addr;

    function automatic logic is_illegal(input logic [2:0] f);
        case (f)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: is_illegal = 1'b0;
            3'b101, 3'b110:                         is_illegal = (DW != 64);
            default:                                is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f, input logic [OW-1:0] off);
        case (f)
            3'b010, 3'b100: is_misaligned = off[0];
            3'b101, 3'b110: is_misaligned = |off[1:0];
            3'b000:         is_misaligned = |off;
            default:        is_misaligned = 1'b0;
        endcase
    endfunction

    // Window is {beat1, beat0}; single-beat loads pass zeros in the upper half.
    function automatic logic [DW-1:0] extract(input logic [2*DW-1:0] win,
                                              input logic [OW-1:0]   off,
                                              input logic [2:0]      f);
        logic [2*DW-1:0] sh;
        logic [DW-1:0]   res;
        logic            fill;
        int              w;
        sh  = win >> {off, 3'b000};
        res = sh[DW-1:0];
        case (f)
            3'b001:  begin w = 8;  fill = 1'b0;   end
            3'b011:  begin w = 8;  fill = sh[7];  end
            3'b010:  begin w = 16; fill = 1'b0;   end
            3'b100:  begin w = 16; fill = sh[15]; end
            3'b101:  begin w = 32; fill = 1'b0;   end
            3'b110:  begin w = 32; fill = sh[31]; end
            default: begin w = DW; fill = 1'b0;   end
        endcase
        for (int i = 0; i < DW; i++) begin
            if (i >= w) res[i] = fill;
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct_d    = funct_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef COCO_LOAD_SPLIT_EN
        split_d    = split_q;
        beat0_d    = beat0_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    funct_d = req_funct;
                    if (is_illegal(req_funct)) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else if (is_misaligned(req_funct, req_addr[OW-1:0])) begin
`ifdef COCO_LOAD_SPLIT_EN
                        split_d = 1'b1;
                        state_d = ISSUE0;
`else
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
`endif
                    end else begin
`ifdef COCO_LOAD_SPLIT_EN
                        split_d = 1'b0;
`endif
                        state_d = ISSUE0;
                    end
                end
            end
            ISSUE0: if (mem_rd_ready) state_d = WAIT0;
            WAIT0: begin
                if (mem_rdata_valid) begin
`ifdef COCO_LOAD_SPLIT_EN
                    beat0_d = mem_rdata;
                    if (split_q) begin
                        state_d = ISSUE1;
                    end else begin
                        state_d    = RESP;
                        rsp_data_d = extract({{DW{1'b0}}, mem_rdata}, addr_q[OW-1:0], funct_q);
                        rsp_err_d  = 1'b0;
                    end
`else
                    state_d    = RESP;
                    rsp_data_d = extract({{DW{1'b0}}, mem_rdata}, addr_q[OW-1:0], funct_q);
                    rsp_err_d  = 1'b0;
`endif
                end
            end
`ifdef COCO_LOAD_SPLIT_EN
            ISSUE1: if (mem_rd_ready) state_d = WAIT1;
            WAIT1: begin
                if (mem_rdata_valid) begin
                    state_d    = RESP;
                    rsp_data_d = extract({mem_rdata, beat0_q}, addr_q[OW-1:0], funct_q);
                    rsp_err_d  = 1'b0;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        base_addr      = {addr_d[31:OW], {OW{1'b0}}};
        req_ready_d    = (state_d == IDLE);
        rsp_valid_d    = (state_d == RESP);
        mem_rd_valid_d = (state_d == ISSUE0);
        mem_rd_addr_d  = mem_rd_addr_q;
        if (state_d == ISSUE0) mem_rd_addr_d = base_addr;
`ifdef COCO_LOAD_SPLIT_EN
        if (state_d == ISSUE1) begin
            mem_rd_valid_d = 1'b1;
            mem_rd_addr_d  = base_addr + 32'(NB);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            funct_q        <= '0;
            req_ready_q    <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            mem_rd_addr_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
`ifdef COCO_LOAD_SPLIT_EN
            split_q        <= 1'b0;
            beat0_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            funct_q        <= funct_d;
            req_ready_q    <= req_ready_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
`ifdef COCO_LOAD_SPLIT_EN
            split_q        <= split_d;
            beat0_q        <= beat0_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign mem_rd_valid = mem_rd_valid_q;
    assign mem_rd_addr  = mem_rd_addr_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_coco_load_align.sv
// Directed bench for coco_load_align (DW=32) with a zero-wait memory responder;
// expectations follow the COCO_LOAD_SPLIT_EN setting of the build.
module tb_coco_load_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct;
    logic        mem_rd_valid, mem_rd_ready, mem_rdata_valid;
    logic [31:0] mem_rd_addr, mem_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    coco_load_align #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct(req_funct),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load: request, serve memory with zero wait, check response, optionally stall rsp_ready.
    task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_reads, input int exp_lat,
                           input logic [31:0] ea0, input logic [31:0] ea1, input int hold);
        int          t, n;
        logic        pend;
        logic [31:0] pd, a0, a1, held;
        req_valid = 1'b1;
        req_addr  = addr;
        req_funct = f;
        check_val({name, ".req_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        t = 1; n = 0; pend = 1'b0; pd = '0; a0 = '0; a1 = '0;
        while (!rsp_valid && t < 20) begin
            mem_rdata_valid = pend;
            mem_rdata       = pd;
            pend            = 1'b0;
            if (mem_rd_valid) begin
                mem_rd_ready = 1'b1;
                if (n == 0) a0 = mem_rd_addr; else a1 = mem_rd_addr;
                pd   = (n == 0) ? d0 : d1;
                pend = 1'b1;
                n++;
            end else begin
                mem_rd_ready = 1'b0;
            end
            tick();
            t++;
        end
        mem_rdata_valid = 1'b0;
        mem_rd_ready    = 1'b0;
        check_val({name, ".latency"}, t, exp_lat);
        check_val({name, ".data"}, rsp_data, exp_data);
        check_val({name, ".err"}, rsp_err, exp_err);
        check_val({name, ".reads"}, n, exp_reads);
        if (exp_reads > 0) check_val({name, ".addr0"}, a0, ea0);
        if (exp_reads > 1) check_val({name, ".addr1"}, a1, ea1);
        held = rsp_data;
        if (hold > 0) begin
            req_valid = 1'b1;
            req_funct = 3'b111;
            req_addr  = 32'h0;
            for (int i = 0; i < hold; i++) begin
                tick();
                check_val({name, ".hold_valid"}, rsp_valid, 1);
                check_val({name, ".hold_data"}, rsp_data, held);
                check_val({name, ".hold_ready"}, req_ready, 0);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val({name, ".rsp_drop"}, rsp_valid, 0);
        check_val({name, ".rsp_zero"}, rsp_data, 0);
        if (hold > 0) begin
            check_val({name, ".next_ready"}, req_ready, 1);
            tick();
            req_valid = 1'b0;
            check_val({name, ".next_rsp"}, rsp_valid, 1);
            check_val({name, ".next_err"}, rsp_err, 1);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        $display("load %s addr=0x%08h funct=%0d -> data=0x%08h err=%0b reads=%0d lat=%0d",
                 name, addr, f, held, exp_err, n, t);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_funct = '0;
        mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        rsp_ready = 1'b0;
        #12;
        check_val("rst.req_ready", req_ready, 0);
        check_val("rst.mem_rd_valid", mem_rd_valid, 0);
        check_val("rst.mem_rd_addr", mem_rd_addr, 0);
        check_val("rst.rsp_valid", rsp_valid, 0);
        check_val("rst.rsp_data", rsp_data, 0);
        check_val("rst.rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        #1;
        check_val("rst.ready_before_edge", req_ready, 0);
        tick();
        check_val("rst.ready_after_edge", req_ready, 1);

        do_load("sbyte",    32'h0000_0103, 3'b011, 32'h80FF_1234, 32'h0, 32'hFFFF_FF80, 0, 1, 3, 32'h100, 32'h0, 0);
        do_load("uhalf",    32'h0000_0102, 3'b010, 32'h8001_7FFF, 32'h0, 32'h0000_8001, 0, 1, 3, 32'h100, 32'h0, 0);
        do_load("full",     32'h0000_0200, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 0, 1, 3, 32'h200, 32'h0, 0);
        do_load("ubyte_hi", 32'hFFFF_FFFF, 3'b001, 32'h7F00_0000, 32'h0, 32'h0000_007F, 0, 1, 3, 32'hFFFF_FFFC, 32'h0, 0);
        do_load("shalf_pos",32'h0000_0010, 3'b100, 32'h1234_7FFF, 32'h0, 32'h0000_7FFF, 0, 1, 3, 32'h10, 32'h0, 0);
        do_load("shalf_neg",32'h0000_0012, 3'b100, 32'h8000_1234, 32'h0, 32'hFFFF_8000, 0, 1, 3, 32'h10, 32'h0, 0);
        do_load("ill_111",  32'h0000_0000, 3'b111, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'h0, 32'h0, 0);
        do_load("ill_word", 32'h0000_0040, 3'b101, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'h0, 32'h0, 0);
`ifdef COCO_LOAD_SPLIT_EN
        do_load("split_sh", 32'h0000_0103, 3'b100, 32'hAABB_CCDD, 32'h1122_33EE, 32'hFFFF_EEAA, 0, 2, 5, 32'h100, 32'h104, 0);
        do_load("split_fw", 32'h0000_0101, 3'b000, 32'h4433_2211, 32'h8877_6655, 32'h5544_3322, 0, 2, 5, 32'h100, 32'h104, 0);
        do_load("split_wrap",32'hFFFF_FFFF,3'b010, 32'h1122_3344, 32'h5566_7788, 32'h0000_8811, 0, 2, 5, 32'hFFFF_FFFC, 32'h0, 0);
`else
        do_load("mis_sh",   32'h0000_0103, 3'b100, 32'hAABB_CCDD, 32'h1122_33EE, 32'h0, 1, 0, 1, 32'h0, 32'h0, 0);
        do_load("mis_fw",   32'h0000_0101, 3'b000, 32'h4433_2211, 32'h8877_6655, 32'h0, 1, 0, 1, 32'h0, 32'h0, 0);
`endif
        do_load("stall",    32'h0000_0103, 3'b011, 32'h80FF_1234, 32'h0, 32'hFFFF_FF80, 0, 1, 3, 32'h100, 32'h0, 5);

        // Reset in the last wait state of a load, then a stray data pulse.
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hFFFF_FFFF;
        tick();
        mem_rdata_valid = 1'b0;
        check_val("idle_pulse.rsp_valid", rsp_valid, 0);
        check_val("idle_pulse.mem_rd_valid", mem_rd_valid, 0);
        req_valid = 1'b1;
`ifdef COCO_LOAD_SPLIT_EN
        req_addr = 32'h0000_0103; req_funct = 3'b100;
        tick();
        req_valid = 1'b0;
        mem_rd_ready = 1'b1; tick();
        mem_rd_ready = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hAABB_CCDD; tick();
        mem_rdata_valid = 1'b0;
        check_val("rst_mid.issue1", mem_rd_valid, 1);
        mem_rd_ready = 1'b1; tick();
        mem_rd_ready = 1'b0;
`else
        req_addr = 32'h0000_0103; req_funct = 3'b011;
        tick();
        req_valid = 1'b0;
        check_val("rst_mid.issue0", mem_rd_valid, 1);
        mem_rd_ready = 1'b1; tick();
        mem_rd_ready = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        check_val("rst_mid.req_ready", req_ready, 0);
        check_val("rst_mid.mem_rd_valid", mem_rd_valid, 0);
        check_val("rst_mid.mem_rd_addr", mem_rd_addr, 0);
        check_val("rst_mid.rsp_valid", rsp_valid, 0);
        check_val("rst_mid.rsp_data", rsp_data, 0);
        tick();
        #2;
        rst_n = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'h1122_33EE;
        tick();
        mem_rdata_valid = 1'b0;
        check_val("rst_mid.ready_back", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check_val("rst_mid.no_rsp", rsp_valid, 0);
            check_val("rst_mid.no_rd", mem_rd_valid, 0);
            tick();
        end
        $display("load rst_mid abandoned, req_ready=%0b rsp_valid=%0b", req_ready, rsp_valid);

        do_load("post_rst", 32'h0000_0102, 3'b010, 32'h8001_7FFF, 32'h0, 32'h0000_8001, 0, 1, 3, 32'h100, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coco_load_align.md
COCO_LOAD_ALIGN -- requirements
Module: coco_load_align

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data/bus width in bits; legal values 32 and 64 only.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: load request present.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-006 SHALL have port req_addr, input, 32 bits: byte address.
REQ-007 SHALL have port req_funct, input, 3 bits: extension code (REQ-016).
REQ-008 SHALL have port mem_rd_valid, output, 1 bit: memory read command.
REQ-009 SHALL have port mem_rd_addr, output, 32 bits: DW/8-aligned read address.
REQ-010 SHALL have port mem_rd_ready, input, 1 bit: memory accepts the command.
REQ-011 SHALL have port mem_rdata_valid, input, 1 bit: read data returned.
REQ-012 SHALL have port mem_rdata, input, DW bits: read data, little-endian byte lanes.
REQ-013 SHALL have port rsp_valid, output, 1 bit: result present.
REQ-014 SHALL have port rsp_ready, input, 1 bit: consumer takes the result.
REQ-015 SHALL have ports rsp_data (output, DW bits: extended result) and rsp_err (output, 1 bit: address or code error).

Function
REQ-016 Codes: 000 full DW; 001 unsigned byte; 010 unsigned half; 011 signed byte; 100 signed half; 101 unsigned word and 110 signed word (DW=64 only); all others illegal.
REQ-017 Byte offset off = req_addr[log2(DW/8)-1:0]; the extracted field starts at byte lane off; unsigned codes zero-fill and signed codes replicate the field MSB up to DW bits.
REQ-018 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; full with off!=0; bytes never.
REQ-019 FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on accept, latch addr/funct; illegal code, or misaligned with split disabled -> RESP with rsp_err=1, rsp_data=0, no memory read; otherwise -> ISSUE0.
REQ-021 ISSUE0: mem_rd_valid=1, mem_rd_addr=addr with low log2(DW/8) bits cleared; on mem_rd_ready -> WAIT0.
REQ-022 WAIT0: on mem_rdata_valid capture beat0; -> ISSUE1 if split, else -> RESP.
REQ-023 ISSUE1/WAIT1: same handshake at beat0 address + DW/8, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0); capture beat1, -> RESP.
REQ-024 Split merge: field taken from the 2*DW concatenation {beat1,beat0} starting at byte off.
REQ-025 RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready; on rsp_ready -> IDLE; next request accepted no earlier than the following cycle.
REQ-026 mem_rdata_valid outside WAIT0/WAIT1 SHALL be ignored; mem_rd_valid SHALL stay high, with a stable address, until mem_rd_ready.
REQ-027 Latency, aligned, zero-wait memory: accept at T, mem_rd_valid at T+1, rdata at T+2, rsp_valid at T+3; split adds 2 cycles.
REQ-028 Outputs SHALL be registered; rsp_data=0 whenever rsp_valid=0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, req_ready=0, mem_rd_valid=0, mem_rd_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, independent of clk.
REQ-030 req_ready SHALL rise on the first clk edge after rst_n deasserts; a transaction in flight at reset SHALL be abandoned with no response.

Configuration
REQ-031 Macro COCO_LOAD_SPLIT_EN defined: misaligned loads SHALL be executed as two aligned reads and merged (REQ-023, REQ-024), rsp_err=0.
REQ-032 Macro COCO_LOAD_SPLIT_EN undefined: ISSUE1/WAIT1 SHALL not exist; misaligned loads SHALL return rsp_err=1, rsp_data=0 with no memory read.

Verification (DW=32)
REQ-033 funct=011, addr=0x0000_0103, rdata=0x80FF_1234 -> rd addr 0x100, rsp_data=0xFFFF_FF80, err=0, rsp_valid at T+3.
REQ-034 funct=010, addr=0x0000_0102, rdata=0x8001_7FFF -> rsp_data=0x0000_8001, err=0.
REQ-035 SPLIT_EN, funct=100, addr=0x103, beat0@0x100=0xAABB_CCDD, beat1@0x104=0x1122_33EE -> rsp_data=0xFFFF_EEAA, err=0.
REQ-036 SPLIT_EN undefined, same request as REQ-035 -> rsp_err=1, rsp_data=0, mem_rd_valid never asserted.
REQ-037 rsp_ready low for 5 cycles in RESP, with req_valid high throughout -> rsp stable, req_ready=0; accepted one cycle after the rsp_ready handshake.
REQ-038 rst_n low in WAIT1, then mem_rdata_valid pulsed after release -> outputs 0 at once, state IDLE, pulse ignored, no rsp_valid.
